// File: rtl/lock_pkg.sv
// Shared types and constants for the passcode lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_UNLOCKED,
    ST_WRONG,
    ST_LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  localparam logic [3:0] PS_LOCKED   = 4'b0001;
  localparam logic [3:0] PS_UNLOCKED = 4'b0010;
  localparam logic [3:0] PS_WRONG    = 4'b0100;
  localparam logic [3:0] PS_LOCKOUT  = 4'b1000;

  // CHECK has no status of its own; it keeps showing LOCKED.
  function automatic logic [3:0] status_of(input state_t s);
    case (s)
      ST_UNLOCKED: return PS_UNLOCKED;
      ST_WRONG:    return PS_WRONG;
      ST_LOCKOUT:  return PS_LOCKOUT;
      default:     return PS_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Saturating up-counter used for both WRONG and LOCKOUT hold times.
// expired is raised in the last cycle of the hold, so the owner leaves
// exactly `limit` clocks after the cycle in which start was seen.
module lock_timer #(
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Restart from zero on start, otherwise count up and stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

  // Terminal count reached once the count sits at limit-1.
  always_comb begin
    expired = (count >= (limit - WIDTH'(1)));
  end

endmodule

// File: rtl/lock_sequencer.sv
// Passcode entry controller: buffers keypad digits, checks them on Enter,
// counts consecutive failures and holds WRONG / LOCKOUT for fixed times.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] PASSCODE       = 16'h1234,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    ERR_CYCLES     = 100_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       lock_button,
  output logic [3:0] pass_signal,
  output logic [2:0] press_count
);

  localparam int BW = 4 * CODE_LEN;
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [2:0]    FULL_COUNT = 3'(CODE_LEN);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAIL);
  localparam logic [TW-1:0] ERR_LIMIT  = TW'(ERR_CYCLES);
  localparam logic [TW-1:0] LOCK_LIMIT = TW'(LOCKOUT_CYCLES);

  state_t          state, state_next;
  logic [BW-1:0]   buffer, buffer_next;
  logic [2:0]      count_next;
  logic [FW-1:0]   fail_count, fail_next, fail_inc;
  logic            button_q;
  logic            button_rise;
  logic            key_is_digit;
  logic            timer_start;
  logic            timer_expired;
  logic [TW-1:0]   timer_limit;

  lock_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (timer_start),
    .limit   (timer_limit),
    .expired (timer_expired)
  );

  // State, digit buffer, fail counter, button history and status register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_LOCKED;
      buffer      <= '0;
      press_count <= '0;
      fail_count  <= '0;
      button_q    <= 1'b0;
      pass_signal <= PS_LOCKED;
    end else begin
      state       <= state_next;
      buffer      <= buffer_next;
      press_count <= count_next;
      fail_count  <= fail_next;
      button_q    <= lock_button;
      pass_signal <= status_of(state_next);
    end
  end

  // Next-state, buffer and fail-count decisions; the button beats any key.
  always_comb begin
    state_next   = state;
    buffer_next  = buffer;
    count_next   = press_count;
    fail_next    = fail_count;
    fail_inc     = fail_count + FW'(1);
    button_rise  = lock_button & ~button_q;
    key_is_digit = (key_code <= 4'd9);
    timer_start  = (state == ST_CHECK);
    timer_limit  = (state == ST_LOCKOUT) ? LOCK_LIMIT : ERR_LIMIT;

    case (state)
      ST_LOCKED: begin
        if (button_rise) begin
          buffer_next = '0;
          count_next  = '0;
        end else if (key_valid) begin
          if (key_is_digit) begin
            if (press_count < FULL_COUNT) begin
              buffer_next = (buffer << 4) | BW'(key_code);
              count_next  = press_count + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            buffer_next = '0;
            count_next  = '0;
          end else if (key_code == KEY_ENTER) begin
            state_next = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        buffer_next = '0;
        count_next  = '0;
        if ((press_count == FULL_COUNT) && (buffer == PASSCODE)) begin
          state_next = ST_UNLOCKED;
          fail_next  = '0;
        end else if (fail_inc == FAIL_LIMIT) begin
          state_next = ST_LOCKOUT;
          fail_next  = '0;
        end else begin
          state_next = ST_WRONG;
          fail_next  = fail_inc;
        end
      end

      ST_UNLOCKED: begin
        if (button_rise || (key_valid && (key_code == KEY_ENTER))) begin
          state_next = ST_LOCKED;
        end
      end

      ST_WRONG, ST_LOCKOUT: begin
        if (timer_expired) begin
          state_next = ST_LOCKED;
        end
      end

      default: begin
        state_next = ST_LOCKED;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with short WRONG / LOCKOUT hold times.
module tb_lock_sequencer;

  localparam logic [3:0] E_LOCKED   = 4'b0001;
  localparam logic [3:0] E_UNLOCKED = 4'b0010;
  localparam logic [3:0] E_WRONG    = 4'b0100;
  localparam logic [3:0] E_LOCKOUT  = 4'b1000;

  logic       clk;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       lock_button;
  logic [3:0] pass_signal;
  logic [2:0] press_count;

  typedef struct {
    string      tag;
    bit         is_ps;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  lock_sequencer #(
    .ERR_CYCLES     (8),
    .LOCKOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .lock_button (lock_button),
    .pass_signal (pass_signal),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic kv, input logic [3:0] kc, input logic btn);
    key_valid   = kv;
    key_code    = kc;
    lock_button = btn;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic expect_ps(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag; e.is_ps = 1'b1; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_pc(input string tag, input logic [2:0] v);
    exp_t e;
    e.tag = tag; e.is_ps = 1'b0; e.val = {1'b0, v};
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t       e;
    logic [3:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.is_ps ? pass_signal : {1'b0, press_count};
      compared++;
      assert (obs === e.val) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  // Type n digits (MS nibble first) then Enter; returns in the CHECK cycle.
  task automatic enter_code(input logic [27:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, seq[4*(n-1-i) +: 4], 1'b0);
    end
    apply_stimulus(1'b1, 4'hF, 1'b0);
  endtask

  // Expect a status for exactly n cycles, then LOCKED.
  task automatic hold_check(input string tag, input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      expect_ps(tag, v);
      apply_stimulus(1'b0, 4'h0, 1'b0);
      check_output();
    end
    expect_ps({tag, "_exit"}, E_LOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();
  endtask

  initial begin
    logic [19:0] lock_keys;
    lock_keys   = 20'h1234F;
    reset_n     = 1'b0;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    lock_button = 1'b0;
    tick();
    tick();
    expect_ps("reset_ps", E_LOCKED);
    expect_pc("reset_pc", 3'd0);
    check_output();
    reset_n = 1'b1;
    tick();

    // Correct code unlocks; button re-locks.
    for (int i = 0; i < 4; i++) begin
      expect_pc("digit_count", 3'(i + 1));
      apply_stimulus(1'b1, 4'(i + 1), 1'b0);
      check_output();
    end
    expect_ps("check_ps", E_LOCKED);
    expect_pc("check_pc", 3'd4);
    apply_stimulus(1'b1, 4'hF, 1'b0);
    check_output();
    expect_ps("unlock_ps", E_UNLOCKED);
    expect_pc("unlock_pc", 3'd0);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();
    apply_stimulus(1'b0, 4'h0, 1'b1);
    expect_ps("relock_button", E_LOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b1);
    check_output();
    apply_stimulus(1'b0, 4'h0, 1'b0);

    // Fifth digit saturates; Enter still unlocks, Enter again re-locks.
    for (int i = 0; i < 5; i++) begin
      expect_pc("sat_count", (i < 4) ? 3'(i + 1) : 3'd4);
      apply_stimulus(1'b1, 4'(i + 1), 1'b0);
      check_output();
    end
    apply_stimulus(1'b1, 4'hF, 1'b0);
    expect_ps("sat_unlock", E_UNLOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();
    apply_stimulus(1'b1, 4'hF, 1'b0);
    expect_ps("enter_relock", E_LOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();

    // Clear mid-entry leaves a short code: WRONG (fail 1).
    expect_pc("clr_a", 3'd1); apply_stimulus(1'b1, 4'h1, 1'b0); check_output();
    expect_pc("clr_b", 3'd2); apply_stimulus(1'b1, 4'h2, 1'b0); check_output();
    expect_pc("clr_c", 3'd0); apply_stimulus(1'b1, 4'hE, 1'b0); check_output();
    expect_pc("clr_d", 3'd1); apply_stimulus(1'b1, 4'h3, 1'b0); check_output();
    expect_pc("clr_e", 3'd2); apply_stimulus(1'b1, 4'h4, 1'b0); check_output();
    apply_stimulus(1'b1, 4'hF, 1'b0);
    hold_check("clr_wrong", E_WRONG, 8);

    // Wrong code (fail 2), then empty Enter (fail 3) trips lockout.
    enter_code(28'h1235, 4);
    hold_check("wrong_hold", E_WRONG, 8);
    apply_stimulus(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      expect_ps("lockout_ps", E_LOCKOUT);
      expect_pc("lockout_pc", 3'd0);
      if (i >= 1 && i <= 5) apply_stimulus(1'b1, lock_keys[4*(5-i) +: 4], 1'b0);
      else                  apply_stimulus(1'b0, 4'h0, 1'b0);
      check_output();
    end
    expect_ps("lockout_exit", E_LOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();

    // Digit coincident with button rise is dropped.
    apply_stimulus(1'b1, 4'h7, 1'b1);
    expect_pc("coincide_pc", 3'd0);
    expect_ps("coincide_ps", E_LOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b1);
    check_output();
    apply_stimulus(1'b0, 4'h0, 1'b0);

    // Fail count was cleared by lockout: two WRONGs, then LOCKOUT.
    enter_code(28'h1235, 4);
    hold_check("rep_wrong1", E_WRONG, 8);
    enter_code(28'h1235, 4);
    hold_check("rep_wrong2", E_WRONG, 8);
    enter_code(28'h1235, 4);
    for (int i = 0; i < 11; i++) begin
      expect_ps("rep_lockout", E_LOCKOUT);
      apply_stimulus(1'b0, 4'h0, 1'b0);
      check_output();
    end

    // Asynchronous reset mid-lockout.
    #3 reset_n = 1'b0;
    #1;
    expect_ps("async_rst_ps", E_LOCKED);
    expect_pc("async_rst_pc", 3'd0);
    check_output();
    tick();
    reset_n = 1'b1;
    tick();
    enter_code(28'h1234, 4);
    expect_ps("post_reset_unlock", E_UNLOCKED);
    apply_stimulus(1'b0, 4'h0, 1'b0);
    check_output();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
